// File: rtl/grf_wport_arbiter_pkg.sv
// Shared widths and request type for the register-file write-port arbiter.
// Imported by the side FIFO and the arbiter top level.
package grf_wport_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wport_req_t;

  // Register 0 is hardwired, so a write or a read tag naming it is inert.
  function automatic logic reg_live(input logic [REG_W-1:0] addr);
    return (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/grf_side_fifo.sv
// DEPTH-entry FIFO holding side write requests, with per-entry address/valid
// taps so the decode hazard compare can see every queued destination.
module grf_side_fifo
  import grf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  wport_req_t                        push_req,
  input  logic                              pop,
  output wport_req_t                        head,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0][REG_W-1:0]       tap_addr,
  output logic [DEPTH-1:0]                  tap_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wport_req_t         mem_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Full blocks push and empty blocks pop, so the two never touch one slot.
  assign do_push_s = push && (count_r != CNT_FULL);
  assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r]   <= push_req;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Parallel address taps for the pending-write compare.
  always_comb begin
    tap_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tap_addr[i] = mem_r[i].addr;
    end
  end

  assign tap_valid = valid_r;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the register file write port between the writeback stage (fixed
// priority) and a queued side requester, with hazard flags and anti-starvation.
module grf_wport_arbiter
  import grf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [REG_W-1:0]  s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic [REG_W-1:0]  rd_a,
  input  logic [REG_W-1:0]  rd_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic              stall_req,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_waddr,
  output logic [DATA_W-1:0] grf_wdata
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic                          w_eff_s;
  logic                          push_s;
  logic                          pop_s;
  logic                          fifo_empty_s;
  wport_req_t                    push_req_s;
  wport_req_t                    head_s;
  logic [CNT_W-1:0]              count_s;
  logic [DEPTH-1:0][REG_W-1:0]   tap_addr_s;
  logic [DEPTH-1:0]              tap_valid_s;
  logic                          sel_we_s;
  logic [REG_W-1:0]              sel_addr_s;
  logic [DATA_W-1:0]             sel_data_s;
  logic [WAIT_W-1:0]             wait_r;
  logic [WAIT_W-1:0]             wait_nxt_s;
  logic                          stall_nxt_s;
  logic                          stall_r;
  logic                          grf_we_r;
  logic [REG_W-1:0]              grf_waddr_r;
  logic [DATA_W-1:0]             grf_wdata_r;
  logic                          pend_a_s;
  logic                          pend_b_s;

  assign w_eff_s      = wb_we && reg_live(wb_addr);
  assign fifo_empty_s = (count_s == {CNT_W{1'b0}});
  assign s_ready      = (count_s < CNT_FULL);
  // Writes to register 0 complete the handshake but are never queued.
  assign push_s       = s_valid && s_ready && reg_live(s_addr);
  assign push_req_s   = '{addr: s_addr, data: s_data};

  grf_side_fifo #(
    .DEPTH(DEPTH)
  ) u_side_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .push_req (push_req_s),
    .pop      (pop_s),
    .head     (head_s),
    .count    (count_s),
    .tap_addr (tap_addr_s),
    .tap_valid(tap_valid_s)
  );

  // Priority select: writeback first, otherwise drain the FIFO head.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = ZERO_REG;
    sel_data_s = {DATA_W{1'b0}};
    pop_s      = 1'b0;
    if (w_eff_s) begin
      sel_we_s   = 1'b1;
      sel_addr_s = wb_addr;
      sel_data_s = wb_data;
    end else if (!fifo_empty_s) begin
      pop_s      = 1'b1;
      sel_we_s   = 1'b1;
      sel_addr_s = head_s.addr;
      sel_data_s = head_s.data;
    end else begin
      sel_we_s   = 1'b0;
    end
  end

  // Head-wait counter and the stall decision it feeds.
  always_comb begin
    wait_nxt_s  = wait_r;
    stall_nxt_s = (wait_r == WAIT_MAX) && !pop_s;
    if (fifo_empty_s || pop_s) begin
      wait_nxt_s = {WAIT_W{1'b0}};
    end else if (wait_r != WAIT_MAX) begin
      wait_nxt_s = wait_r + WAIT_ONE;
    end else begin
      wait_nxt_s = wait_r;
    end
  end

  // Hazard compare against every queued entry; the output register is excluded.
  always_comb begin
    pend_a_s = 1'b0;
    pend_b_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_a_s = pend_a_s | (tap_valid_s[i] && (tap_addr_s[i] == rd_a));
      pend_b_s = pend_b_s | (tap_valid_s[i] && (tap_addr_s[i] == rd_b));
    end
    pend_a_s = pend_a_s && reg_live(rd_a);
    pend_b_s = pend_b_s && reg_live(rd_b);
  end

  // Write-port output registers, wait counter and stall request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we_r    <= 1'b0;
      grf_waddr_r <= ZERO_REG;
      grf_wdata_r <= {DATA_W{1'b0}};
      wait_r      <= {WAIT_W{1'b0}};
      stall_r     <= 1'b0;
    end else begin
      grf_we_r    <= sel_we_s;
      grf_waddr_r <= sel_addr_s;
      grf_wdata_r <= sel_data_s;
      wait_r      <= wait_nxt_s;
      stall_r     <= stall_nxt_s;
    end
  end

  assign grf_we    = grf_we_r;
  assign grf_waddr = grf_waddr_r;
  assign grf_wdata = grf_wdata_r;
  assign stall_req = stall_r;
  assign pend_a    = pend_a_s;
  assign pend_b    = pend_b_s;

endmodule
